// File: rtl/bin_to_bcd_4_digits.sv
`default_nettype none
// ============================================================================
// Module      : bin_to_bcd_4_digits
// Description : Iterative binary to 4-digit packed BCD converter using
//               shift-and-add-3, one binary bit per clock. Accepts a value on
//               a valid/ready handshake and presents the result on a held
//               register so downstream display logic never sees partial
//               digits.
//               Optional build macro BIN_TO_BCD_SATURATE_EN: when defined,
//               an input above 9999 produces 16'h9999 instead of the low
//               four decimal digits.
// Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd_4_digits #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] bin,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [15:0]  bcd,
    output logic         done,
    output logic         overflow
);

    // Shift register holds {16-bit BCD scratch, W-bit binary}.
    localparam int          SW         = W + 16;
    localparam logic [4:0]  C_W_COUNT  = 5'(W);
    localparam logic [16:0] C_MAX_DEC  = 17'd9999;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q,    state_d;
    logic [SW-1:0]   shift_q,    shift_d;
    logic [4:0]      cnt_q,      cnt_d;
    logic            pending_q,  pending_d;
    logic [15:0]     bcd_q,      bcd_d;
    logic            done_q,     done_d;
    logic            overflow_q, overflow_d;

    logic            w_accept;
    logic            w_last;
    logic            w_bin_big;
    logic [15:0]     w_scratch_adj;
    logic [SW-1:0]   w_shifted;

    assign in_ready = (state_q == IDLE);
    assign w_accept = in_valid & in_ready;

    // The cycle whose shift is the W-th one is the completion cycle.
    assign w_last   = (cnt_q == 5'd1);

    // Zero-extend to 17 bits so the compare is legal for every W in 4..16;
    // for small W it simply never fires.
    assign w_bin_big = ({{(17 - W){1'b0}}, bin} > C_MAX_DEC);

    // Add-3 correction on every scratch nibble that would reach >= 10 after
    // the following doubling.
    for (genvar g = 0; g < 4; g++) begin : g_nibble_adj
        logic [3:0] w_nib;
        assign w_nib = shift_q[W + 4*g +: 4];
        assign w_scratch_adj[4*g +: 4] = (w_nib >= 4'd5) ? (w_nib + 4'd3) : w_nib;
    end

    // Shift the corrected scratch together with the binary part; the bit
    // leaving scratch bit 15 is dropped, so the scratch keeps bin mod 10000.
    assign w_shifted = {w_scratch_adj, shift_q[W-1:0]} << 1;

    // Next-state, datapath and output-register computation.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    shift_d   = {16'h0000, bin};
                    cnt_d     = C_W_COUNT;
                    pending_d = w_bin_big;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                shift_d = w_shifted;
                cnt_d   = cnt_q - 5'd1;
                if (w_last) begin
                    state_d    = IDLE;
                    done_d     = 1'b1;
                    overflow_d = pending_q;
`ifdef BIN_TO_BCD_SATURATE_EN
                    bcd_d      = pending_q ? 16'h9999 : w_shifted[SW-1:W];
`else
                    bcd_d      = w_shifted[SW-1:W];
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any conversion in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= 5'd0;
            pending_q  <= 1'b0;
            bcd_q      <= 16'h0000;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            bcd_q      <= bcd_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

    assign bcd      = bcd_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: doc/bin_to_bcd_4_digits.md
Name: bin_to_bcd_4_digits

Overview:
Iterative binary-to-packed-BCD converter (shift-and-add-3, one bit per clock) that feeds the 4-digit seven-segment display driver's 16-bit number input.
- Takes an unsigned binary value through a valid/ready handshake.
- Produces four BCD digits on a held output register, so the display never shows intermediate values.
- Sits between measurement/recognition logic (counters, note index) and the display stage.

Parameters:
W, 14, input binary width; legal 4..16; conversion takes W shift cycles.

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
bin  input  W  unsigned binary value; sampled only on accept
in_valid  input  1  bin is valid this cycle
in_ready  output  1  converter idle, can accept
bcd  output  16  packed BCD result; [15:12] thousands … [3:0] units; held between conversions
done  output  1  one-cycle pulse: bcd just updated
overflow  output  1  last accepted bin > 9999; held with bcd

Behaviour:
- Reset (async, active-high):
  - state=IDLE, in_ready=1, bcd=16'h0000, done=0, overflow=0.
  - Any conversion in progress is discarded; reset wins over all other events.
- States: IDLE, SHIFT.
- in_ready = (state==IDLE), combinational from the state register.
- Accept: edge where in_valid & in_ready.
  - Capture bin into shift register (W bits binary + 16 bits BCD scratch, scratch cleared).
  - Capture overflow_pending = (bin > 9999).
  - Bit counter = W; go to SHIFT.
- SHIFT, each edge:
  - Every scratch nibble >= 5 gets +3.
  - Then the whole {scratch, binary} register shifts left by 1, MSB of binary entering scratch bit 0.
  - Counter decrements.
  - Bits shifted out of scratch bit 15 are discarded, so the scratch holds bin mod 10000.
- On the edge performing the W-th shift:
  - bcd <= final scratch (post-shift), overflow <= overflow_pending.
  - done=1 for the following cycle; state <= IDLE.
- Latency: accept at edge t -> bcd/done/overflow updated at edge t+W. Back-to-back throughput is one conversion per W+1 cycles.
- done and in_ready are both high in the first IDLE cycle after a conversion. If in_valid is high then, that input is accepted on the same edge that clears done.
- in_valid while busy (in_ready=0) is ignored; no queuing. bin may change freely when not accepted.
- bcd and overflow change only on a completion edge or reset; they are stable for the display at all other times.
- No nibble of bcd ever exceeds 9.
- W < 14: overflow is constant 0, because max input < 9999 cannot occur only when 2^W-1 <= 9999. For W<=13 the comparator still exists but never fires.

Optional Feature:
BIN_TO_BCD_SATURATE_EN
- Defined: when overflow_pending is set at completion, bcd <= 16'h9999 instead of the scratch value; overflow=1 as usual.
- Undefined: bcd = low four decimal digits (bin mod 10000); overflow=1 flags the truncation.
- Latency and handshake are identical in both builds.

Test Plan:
- After reset, no stimulus -> bcd=16'h0000, in_ready=1, done=0, overflow=0.
- W=14, accept bin=1234 at edge t -> in_ready=0 for edges t+1..t+14. bcd=16'h1234, done=1, overflow=0 after edge t+14, and done=0 one cycle later.
- bin=9999 then, accepted in the done cycle, bin=0 -> bcd=16'h9999, then 16'h0000 after another 14 edges; no idle gap between conversions.
- bin=16383 -> overflow=1. bcd=16'h6383 without the macro; bcd=16'h9999 with BIN_TO_BCD_SATURATE_EN.
- Accept 4321, pulse in_valid with bin=5555 at cycle t+5 -> ignored; result 16'h4321. bcd holds the prior value until the completion edge.
- Accept 777, assert reset at cycle t+7 for 1 cycle -> bcd=0, done never pulses, in_ready=1. A fresh accept of 42 gives 16'h0042 after 14 edges.
